// File: rtl/cpu6502_int_ctrl.sv
// Interrupt front-end for the cpu6502 core: input synchronisers, NMI edge latch,
// IRQ masking and the RESET > NMI > IRQ/BRK request/vector handshake.
module cpu6502_int_ctrl #(
    parameter int                 NUM_IRQ     = 8,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] MASK_RESET  = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               nmi_in,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               poll,
    input  logic               i_flag,
    input  logic               brk_seq,
    input  logic               int_ack,
    input  logic               vec_fetch,
    output logic               int_req,
    output logic [7:0]         vector_lo,
    output logic               push_b,
    output logic [NUM_IRQ-1:0] irq_status,
    output logic               nmi_pending,
    output logic               proto_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_SEQ} state_t;
    typedef enum logic [1:0] {K_RESET, K_NMI, K_IRQ, K_BRK} kind_t;

    logic [SYNC_STAGES-1:0] nmi_sync_q;
    logic [NUM_IRQ-1:0]     irq_sync_q [SYNC_STAGES];
    logic                   nmi_prev_q;
    logic [NUM_IRQ-1:0]     irq_mask_q;
    logic                   nmi_pend_q, nmi_pend_d;
    logic                   proto_err_q, proto_err_d;
    logic                   brk_q, brk_d;
    state_t                 state_q, state_d;
    kind_t                  kind_q, kind_d;

    logic nmi_edge;
    logic nmi_clear;
    logic irq_active;

    assign nmi_edge   = nmi_sync_q[SYNC_STAGES-1] & ~nmi_prev_q;
    assign irq_status = irq_sync_q[SYNC_STAGES-1] & irq_mask_q;
    assign irq_active = |irq_status;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nmi_sync_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) irq_sync_q[i] <= '0;
            nmi_prev_q <= 1'b0;
        end else begin
            nmi_sync_q    <= {nmi_sync_q[SYNC_STAGES-2:0], nmi_in};
            irq_sync_q[0] <= irq_src;
            for (int i = 1; i < SYNC_STAGES; i++) irq_sync_q[i] <= irq_sync_q[i-1];
            nmi_prev_q <= nmi_sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask_q  <= MASK_RESET;
            nmi_pend_q  <= 1'b0;
            proto_err_q <= 1'b0;
            brk_q       <= 1'b0;
            state_q     <= ST_SEQ;
            kind_q      <= K_RESET;
        end else begin
            if (mask_wr) irq_mask_q <= mask_wdata;
            nmi_pend_q  <= nmi_pend_d;
            proto_err_q <= proto_err_d;
            brk_q       <= brk_d;
            state_q     <= state_d;
            kind_q      <= kind_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        brk_d       = brk_q;
        proto_err_d = proto_err_q;
        nmi_clear   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (brk_seq) begin
                    state_d = ST_SEQ;
                    kind_d  = K_BRK;
                    brk_d   = 1'b1;
                end else if (poll && nmi_pend_q) begin
                    state_d = ST_ARMED;
                    kind_d  = K_NMI;
                    brk_d   = 1'b0;
                end else if (poll && irq_active && !i_flag) begin
                    state_d = ST_ARMED;
                    kind_d  = K_IRQ;
                    brk_d   = 1'b0;
                end
            end
            ST_ARMED: begin
                if (int_ack) state_d = ST_SEQ;
            end
            ST_SEQ: begin
                if (vec_fetch) begin
                    state_d   = ST_IDLE;
                    nmi_clear = (kind_q == K_NMI);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Hijack only changes the vector; a hijacked BRK still pushes B=1 via brk_q.
        if (state_q != ST_IDLE && (kind_q == K_IRQ || kind_q == K_BRK) && nmi_pend_q)
            kind_d = K_NMI;
        if ((int_ack && state_q != ST_ARMED) || (vec_fetch && state_q != ST_SEQ) ||
            (brk_seq && state_q != ST_IDLE))
            proto_err_d = 1'b1;
        nmi_pend_d = nmi_edge | (nmi_pend_q & ~nmi_clear);
    end

    always_comb begin
        vector_lo = 8'hFE;
        if (state_q != ST_IDLE) begin
            unique case (kind_q)
                K_NMI:   vector_lo = 8'hFA;
                K_RESET: vector_lo = 8'hFC;
                default: vector_lo = 8'hFE;
            endcase
        end
    end

    assign int_req     = (state_q == ST_ARMED);
    assign push_b      = brk_q && (state_q != ST_IDLE);
    assign nmi_pending = nmi_pend_q;
    assign proto_err   = proto_err_q;

endmodule
